vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Display-side consumer of the output pixel FIFO filled by the frame-buffer memory stage.
- Generates 640x480 VGA timing and pulls one pixel per active cycle from the FIFO.
- Issues the per-frame display request that starts the memory stage streaming a frame.
- Detects FIFO underflow, flushes the FIFO and resynchronises on the next frame boundary.

Parameters:
DATA_WIDTH, 12, pixel width (RGB444)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
REQ_LEN, 4, cycles o_req is held high per request

Ports:
i_clk  in  1  pixel clock; all logic on rising edge
i_rstn  in  1  asynchronous active-low reset
o_req  out  1  display request to memory stage; high for REQ_LEN cycles
o_fifo_flush  out  1  one-cycle flush of the output pixel FIFO
o_rd  out  1  FIFO read enable; data valid on i_rdata the following cycle
i_rdata  in  DATA_WIDTH  FIFO read data
i_empty  in  1  FIFO empty flag
i_almostempty  in  1  FIFO almost-empty flag
o_rgb  out  DATA_WIDTH  pixel out; 0 when blanked
o_de  out  1  data enable (active video)
o_hsync  out  1  horizontal sync, active-low
o_vsync  out  1  vertical sync, active-low
o_underflow  out  1  sticky underflow flag; cleared at next request

Behaviour:
- Reset (async, i_rstn=0): h_cnt=0, v_cnt=0, state=IDLE. Outputs o_req=0, o_fifo_flush=0, o_rd=0, o_rgb=0, o_de=0, o_underflow=0, o_hsync=1, o_vsync=1. Pipeline registers clear.
- Counters: h_cnt 0..H_TOT-1, where H_TOT = sum of the four H_* parameters = 800. It wraps to 0 and then increments v_cnt. v_cnt 0..V_TOT-1 (525) and wraps. Counters are 10 bits and free-run in every state.
- Region decode on the counter value:
  - active: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync low: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync low: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Event VS_START: h_cnt==0 && v_cnt==V_ACTIVE+V_FP. Event FRAME_START: h_cnt==0 && v_cnt==0.
- Pipeline: o_rd for pixel (h,v) is asserted in the cycle the counters equal (h,v). The FIFO returns data in the next cycle, and it is registered into o_rgb. o_rgb, o_de, o_hsync and o_vsync for (h,v) appear exactly 2 cycles after that counter value. Sync and de are delayed through matching registers so all outputs stay aligned.
- o_req: asserted starting the cycle after the triggering event, held REQ_LEN cycles, then 0. When o_req rises, o_underflow clears.
- FSM states and transitions:
  - IDLE: no reads; video blanked (o_rgb=0, syncs still generated). On VS_START: pulse o_req, go to PRIME.
  - PRIME: no reads. On FRAME_START: if !i_almostempty go to STREAM; otherwise blank the whole frame, stay in PRIME, and pulse o_req again at the next VS_START.
  - STREAM: on every active position, o_rd = !i_empty. o_rgb = captured i_rdata when a read occurred. On VS_START: pulse o_req and stay in STREAM.
    - Underflow (active position with i_empty=1): no read issued, that pixel outputs 0, o_underflow<=1, go to RESYNC.
  - RESYNC: no reads; the rest of the frame is blanked. On VS_START: o_fifo_flush=1 for that cycle, o_req sequence starts the following cycle, go to PRIME.
- Pixels never read are output as 0 with o_de still following timing.
- The FIFO is never read outside the active region, and never read while i_empty=1.
- Underflow and VS_START cannot coincide, since VS_START is always in blanking.
- FIFO ownership: the memory stage holds the write side; this block holds the read side and the flush.

Test Plan:
- Reset then run 2 frames, FIFO kept non-empty -> hsync period 800 cycles with low width 96 starting h=656; vsync low on lines 490-491; o_de high 640x480 per frame.
- After reset -> first o_req rises 1 cycle after (h=0,v=490), lasts 4 cycles; no o_rd before the frame following a PRIME with !i_almostempty.
- STREAM with incrementing FIFO data 0x001,0x002.. -> o_rgb shows 0x001 at first o_de cycle, exactly 2 cycles after o_rd at (0,0); 307200 reads per frame.
- Force i_empty=1 at pixel (100,5) -> no o_rd that cycle, o_rgb=0, o_underflow=1, no reads until VS_START; o_fifo_flush pulse at (0,490), o_req next cycle, o_underflow clears.
- In PRIME, hold i_almostempty=1 at FRAME_START -> whole frame blanked, zero reads, second o_req at next VS_START.
- Assert i_rstn=0 mid-line in STREAM -> all outputs immediately at reset values without clock edge; after release, sequence restarts from IDLE.

Source files
------------

// File: rtl/vga_frame_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_frame_reader : VGA timing generator and output-FIFO consumer.
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_frame_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int REQ_LEN    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_req,
  output logic                  o_fifo_flush,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_empty,
  input  logic                  i_almostempty,
  output logic [DATA_WIDTH-1:0] o_rgb,
  output logic                  o_de,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_underflow
);

  localparam int         c_H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_H_LAST   = 10'(c_H_TOT - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_V_TOT - 1);
  localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int         c_REQ_W    = $clog2(REQ_LEN + 1);
  localparam logic [c_REQ_W-1:0] c_REQ_LEN = c_REQ_W'(REQ_LEN);
  localparam logic [c_REQ_W-1:0] c_REQ_ONE = c_REQ_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_RESYNC = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [9:0]           r_h_cnt;
  logic [9:0]           r_v_cnt;
  logic [c_REQ_W-1:0]   r_req_cnt;
  logic                 r_underflow;
  logic                 r_rd_d;
  logic                 r_de_d;
  logic                 r_hs_d;
  logic                 r_vs_d;
  logic [DATA_WIDTH-1:0] r_rgb;
  logic                 r_de;
  logic                 r_hs;
  logic                 r_vs;

  logic w_active;
  logic w_hs_n;
  logic w_vs_n;
  logic w_vs_start;
  logic w_frame_start;
  logic w_stream;
  logic w_flush;
  logic w_rd;
  logic w_uf;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign w_active      = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign w_hs_n        = !((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
  assign w_vs_n        = !((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));
  assign w_vs_start    = (r_h_cnt == 10'd0) && (r_v_cnt == c_VS_BEG);
  assign w_frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving PRIME at frame start must already read pixel (0,0) in that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_stream    = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vs_start) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (w_frame_start && !i_almostempty) begin
          w_stream    = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        w_stream = 1'b1;
      end
      S_RESYNC: begin
        if (w_vs_start) begin
          w_flush     = 1'b1;
          w_state_nxt = S_PRIME;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_stream && w_active && i_empty) w_state_nxt = S_RESYNC;
  end

  assign w_rd = w_stream && w_active && !i_empty;
  assign w_uf = w_stream && w_active && i_empty;

  // Every state re-requests at VS_START, so the request is keyed to the event alone.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_req_cnt   <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_vs_start) begin
        r_req_cnt <= c_REQ_LEN;
      end else if (r_req_cnt != '0) begin
        r_req_cnt <= r_req_cnt - c_REQ_ONE;
      end
      if (w_vs_start) begin
        r_underflow <= 1'b0;
      end else if (w_uf) begin
        r_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rd_d <= 1'b0;
      r_de_d <= 1'b0;
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
      r_rgb  <= '0;
      r_de   <= 1'b0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
    end else begin
      r_rd_d <= w_rd;
      r_de_d <= w_active;
      r_hs_d <= w_hs_n;
      r_vs_d <= w_vs_n;
      r_rgb  <= r_rd_d ? i_rdata : '0;
      r_de   <= r_de_d;
      r_hs   <= r_hs_d;
      r_vs   <= r_vs_d;
    end
  end

  assign o_req        = (r_req_cnt != '0);
  assign o_fifo_flush = w_flush;
  assign o_rd         = w_rd;
  assign o_rgb        = r_rgb;
  assign o_de         = r_de;
  assign o_hsync      = r_hs;
  assign o_vsync      = r_vs;
  assign o_underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_frame_reader : frame-table plus per-cycle scoreboard bench, reduced timing.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_frame_reader;

  localparam int DW = 12;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int RL = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int M_IDLE = 0, M_PRIME = 1, M_STREAM = 2, M_RESYNC = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          empty = 1'b0;
  logic          aempty = 1'b0;
  logic          o_req, o_fifo_flush, o_rd, o_de, o_hsync, o_vsync, o_underflow;
  logic [DW-1:0] o_rgb;

  vga_frame_reader #(
    .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .REQ_LEN(RL)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .o_req(o_req), .o_fifo_flush(o_fifo_flush),
    .o_rd(o_rd), .i_rdata(rdata), .i_empty(empty), .i_almostempty(aempty),
    .o_rgb(o_rgb), .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ae;
    int uf_h;
    int uf_v;
    int reads;
    int reqs;
    int flush;
  } row_t;

  row_t rows[8];
  int total = 0;
  int bad = 0;

  int bh, bv, mode, req_left, exp_ptr, fifo_ptr;
  logic exp_uf, prev_rd_act, prev_req;
  logic vs_ev, fs_ev, stream_now, e_rd, e_uf_ev;
  int cur_ae, cur_uf_h, cur_uf_v;
  int n_rd, n_req, n_flush, n_de;
  logic [DW+2:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (h=%0d v=%0d t=%0t)", name, act, exp, bh, bv, $time);
    end
  endtask

  task automatic reset_checks();
    check("rst o_req", o_req, 0);
    check("rst o_fifo_flush", o_fifo_flush, 0);
    check("rst o_rd", o_rd, 0);
    check("rst o_rgb", o_rgb, 0);
    check("rst o_de", o_de, 0);
    check("rst o_underflow", o_underflow, 0);
    check("rst o_hsync", o_hsync, 1);
    check("rst o_vsync", o_vsync, 1);
  endtask

  task automatic model_reset();
    bh = 0; bv = 0; mode = M_IDLE; req_left = 0; exp_uf = 1'b0;
    prev_rd_act = 1'b0; prev_req = 1'b0; exp_ptr = fifo_ptr;
    sb.delete();
    sb.push_back({1'b0, 1'b1, 1'b1, {DW{1'b0}}});
    sb.push_back({1'b0, 1'b1, 1'b1, {DW{1'b0}}});
  endtask

  task automatic drive_and_check();
    logic active;
    logic [DW+2:0] exp_px;
    active = (bh < HA) && (bv < VA);
    empty  = (bh == cur_uf_h) && (bv == cur_uf_v);
    aempty = cur_ae[0];
    if (prev_rd_act) begin
      rdata = DW'(fifo_ptr);
      fifo_ptr++;
    end
    #1;
    vs_ev      = (bh == 0) && (bv == VA + VF);
    fs_ev      = (bh == 0) && (bv == 0);
    stream_now = (mode == M_STREAM) || ((mode == M_PRIME) && fs_ev && !aempty);
    e_rd       = stream_now && active && !empty;
    e_uf_ev    = stream_now && active && empty;
    check("o_rd", o_rd, e_rd);
    check("o_fifo_flush", o_fifo_flush, (mode == M_RESYNC) && vs_ev);
    check("o_req", o_req, req_left != 0);
    check("o_underflow", o_underflow, exp_uf);
    sb.push_back({active, !((bh >= HA + HF) && (bh < HA + HF + HS)),
                  !((bv >= VA + VF) && (bv < VA + VF + VS)),
                  e_rd ? DW'(exp_ptr) : DW'(0)});
    if (e_rd) exp_ptr++;
    exp_px = sb.pop_front();
    check("pixel {de,hs,vs,rgb}", {o_de, o_hsync, o_vsync, o_rgb}, exp_px);
    n_rd    += int'(o_rd);
    n_flush += int'(o_fifo_flush);
    n_de    += int'(o_de);
    if (o_req && !prev_req) n_req++;
    prev_req    = o_req;
    prev_rd_act = o_rd;
  endtask

  task automatic advance_model();
    if (vs_ev) req_left = RL;
    else if (req_left > 0) req_left--;
    if (vs_ev) exp_uf = 1'b0;
    else if (e_uf_ev) exp_uf = 1'b1;
    case (mode)
      M_IDLE:   if (vs_ev) mode = M_PRIME;
      M_PRIME:  if (stream_now) mode = M_STREAM;
      M_RESYNC: if (vs_ev) mode = M_PRIME;
      default:  ;
    endcase
    if (e_uf_ev) mode = M_RESYNC;
    bh++;
    if (bh == HT) begin
      bh = 0;
      bv++;
      if (bv == VT) bv = 0;
    end
  endtask

  task automatic step();
    drive_and_check();
    advance_model();
    @(negedge clk);
  endtask

  task automatic run_frame(input row_t r);
    cur_ae = r.ae; cur_uf_h = r.uf_h; cur_uf_v = r.uf_v;
    n_rd = 0; n_req = 0; n_flush = 0; n_de = 0;
    repeat (HT * VT) step();
    check("frame reads", n_rd, r.reads);
    check("frame req rises", n_req, r.reqs);
    check("frame flushes", n_flush, r.flush);
    check("frame de cycles", n_de, HA * VA);
  endtask

  initial begin
    // {ae, uf_h, uf_v, reads, req rises, flushes}
    rows[0] = '{0, -1, -1, 0,       1, 0};  // IDLE after reset
    rows[1] = '{0, -1, -1, HA * VA, 1, 0};  // first streamed frame
    rows[2] = '{0,  3,  1, HA + 3,  1, 1};  // underflow at (3,1)
    rows[3] = '{1, -1, -1, 0,       1, 0};  // PRIME, almost-empty at frame start
    rows[4] = '{0, -1, -1, HA * VA, 1, 0};  // PRIME succeeds
    rows[5] = '{0, -1, -1, HA * VA, 1, 0};
    rows[6] = '{0, -1, -1, 0,       1, 0};  // IDLE after mid-line reset
    rows[7] = '{0, -1, -1, HA * VA, 1, 0};
    fifo_ptr = 1;
    cur_ae = 0; cur_uf_h = -1; cur_uf_v = -1;
    bh = 0; bv = 0;

    #2 rstn = 1'b0;
    #1 reset_checks();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) run_frame(rows[i]);

    cur_ae = 0; cur_uf_h = -1; cur_uf_v = -1;
    repeat (2 * HT + 4) step();
    drive_and_check();
    check("streaming before reset", o_rd, 1);
    #1 rstn = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    run_frame(rows[6]);
    run_frame(rows[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
